mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 204 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store port between the EX/MEM stage and a req/ack data memory, with timeout abort.
// Build option: define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of forcing alignment.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic [2:0]  funct3_in,
    input  logic        hold_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic [31:0] load_data_out,
    output logic        bus_err,
    output logic        misalign_err,
    output logic [1:0]  state_dbg_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [7:0] TIMEOUT_Q = 8'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] ldata_q, ldata_d;
    logic        berr_q, berr_d;
    logic        merr_q, merr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        load_q, load_d;

    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_ext;
    logic        trap_misalign;

`ifdef MISALIGN_TRAP_EN
    assign trap_misalign = ((funct3_in[1:0] == 2'b01) && addr_in[0]) ||
                           ((funct3_in == 3'b010) && (addr_in[1:0] != 2'b00));
`else
    assign trap_misalign = 1'b0;
`endif

    always_comb begin
        be_in    = 4'b1111;
        wdata_in = store_data_in;
        case (funct3_in)
            3'b000: begin
                be_in    = 4'b0001 << addr_in[1:0];
                wdata_in = {4{store_data_in[7:0]}};
            end
            3'b001: begin
                be_in    = 4'b0011 << {addr_in[1], 1'b0};
                wdata_in = {2{store_data_in[15:0]}};
            end
            default: ;
        endcase
    end

    // Half-word lane uses only off_q[1], so an odd half address is naturally aligned down.
    always_comb begin
        rbyte = dmem_rdata[{off_q, 3'b000} +: 8];
        rhalf = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{rbyte[7]}}, rbyte};
            3'b100:  load_ext = {24'd0, rbyte};
            3'b001:  load_ext = {{16{rhalf[15]}}, rhalf};
            3'b101:  load_ext = {16'd0, rhalf};
            default: load_ext = dmem_rdata;
        endcase
    end

    // Handshake: dmem_req rises the edge after an access is accepted in IDLE; req/we/addr/
    // wdata/be then stay frozen until the edge that samples dmem_ack high. Ack is ignored
    // outside REQ.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        ldata_d   = ldata_q;
        berr_d    = berr_q;
        merr_d    = merr_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        off_d     = off_q;
        load_d    = load_q;
        mem_stall = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_read_in || mem_write_in) begin
                    mem_stall = 1'b1;
                    f3_d      = funct3_in;
                    off_d     = addr_in[1:0];
                    load_d    = ~mem_write_in;
                    cnt_d     = 8'd0;
                    if (trap_misalign) begin
                        state_d = S_DONE;
                        merr_d  = 1'b1;
                        ldata_d = 32'd0;
                    end else begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                        we_d    = mem_write_in;
                        addr_d  = {addr_in[31:2], 2'b00};
                        wdata_d = wdata_in;
                        be_d    = be_in;
                    end
                end
            end
            S_REQ: begin
                mem_stall = 1'b1;
                if (dmem_ack) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    if (load_q) ldata_d = load_ext;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == TIMEOUT_Q) begin
                        state_d = S_DONE;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        ldata_d = 32'd0;
                        berr_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!hold_in) begin
                    state_d = S_IDLE;
                    berr_d  = 1'b0;
                    merr_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            ldata_q <= 32'd0;
            berr_q  <= 1'b0;
            merr_q  <= 1'b0;
            cnt_q   <= 8'd0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ldata_q <= ldata_d;
            berr_q  <= berr_d;
            merr_q  <= merr_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            load_q  <= load_d;
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign dmem_be       = be_q;
    assign load_data_out = ldata_q;
    assign bus_err       = berr_q;
    assign misalign_err  = merr_q;
    assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: hand-computed vector table, randomized accesses against a
// byte-level model, and a reset-during-request sequence. Honors MISALIGN_TRAP_EN.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_in, mem_write_in, hold_in, dmem_ack;
    logic [31:0] addr_in, store_data_in, dmem_rdata;
    logic [2:0]  funct3_in;
    logic        dmem_req, dmem_we, mem_stall, bus_err, misalign_err;
    logic [31:0] dmem_addr, dmem_wdata, load_data_out;
    logic [3:0]  dmem_be;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .addr_in(addr_in), .store_data_in(store_data_in), .funct3_in(funct3_in),
        .hold_in(hold_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_stall(mem_stall), .load_data_out(load_data_out),
        .bus_err(bus_err), .misalign_err(misalign_err),
        .state_dbg_o(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [2:0]  f3;
        int          ack_lat;   // REQ cycles before ack; -1 never acks
        logic [31:0] rdata;
        int          hold_n;
    } vec_t;

    typedef struct {
        int          stalls;
        int          reqc;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] ld;
        logic        berr;
        logic        merr;
    } exp_t;

    typedef struct {
        vec_t v;
        exp_t e;
    } rec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] sd, input logic [2:0] f3, input int al,
                                input logic [31:0] rdat, input int hn, input int st,
                                input int rc, input logic [31:0] ea, input logic [3:0] be,
                                input logic [31:0] wd, input logic [31:0] ld,
                                input logic berr, input logic merr);
        rec_t r;
        r.v.rd = rd; r.v.wr = wr; r.v.addr = a; r.v.sd = sd; r.v.f3 = f3;
        r.v.ack_lat = al; r.v.rdata = rdat; r.v.hold_n = hn;
        r.e.stalls = st; r.e.reqc = rc; r.e.addr = ea; r.e.we = wr; r.e.be = be;
        r.e.wdata = wd; r.e.ld = ld; r.e.berr = berr; r.e.merr = merr;
        return r;
    endfunction

    // Reference model: works on byte lanes and integer arithmetic.
    function automatic exp_t model(input vec_t v, input logic [31:0] prev_ld);
        exp_t        e;
        logic [7:0]  b[4];
        int          lane, hb, val;
        logic [31:0] ld_val;
        bit          mis;
        for (int i = 0; i < 4; i++) b[i] = v.rdata[8*i +: 8];
        lane = int'(v.addr[1:0]);
        hb   = (lane / 2) * 2;
        mis  = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (v.f3 == 3'b001 || v.f3 == 3'b101) mis = (lane % 2) != 0;
        else if (v.f3 == 3'b010) mis = lane != 0;
`endif
        e.addr = v.addr - 32'(lane);
        e.we   = v.wr;
        case (v.f3)
            3'b000: begin
                e.be    = 4'(1 << lane);
                e.wdata = 32'(v.sd[7:0]) * 32'h01010101;
            end
            3'b001: begin
                e.be    = 4'(3 << hb);
                e.wdata = 32'(v.sd[15:0]) * 32'h00010001;
            end
            default: begin
                e.be    = 4'hF;
                e.wdata = v.sd;
            end
        endcase
        ld_val = v.rdata;
        if (v.f3 == 3'b000 || v.f3 == 3'b100) begin
            val = int'(b[lane]);
            if (v.f3 == 3'b000 && val >= 128) val -= 256;
            ld_val = 32'(val);
        end else if (v.f3 == 3'b001 || v.f3 == 3'b101) begin
            val = int'(b[hb]) + 256 * int'(b[hb+1]);
            if (v.f3 == 3'b001 && val >= 32768) val -= 65536;
            ld_val = 32'(val);
        end
        e.berr = 1'b0;
        e.merr = 1'b0;
        if (mis) begin
            e.stalls = 1; e.reqc = 0; e.ld = 32'd0; e.merr = 1'b1;
        end else if (v.ack_lat < 0) begin
            e.stalls = 1 + TO; e.reqc = TO; e.ld = 32'd0; e.berr = 1'b1;
        end else begin
            e.reqc = v.ack_lat + 1; e.stalls = 1 + e.reqc;
            e.ld = v.wr ? prev_ld : ld_val;
        end
        return e;
    endfunction

    task automatic run_access(input string tag, input vec_t v, output exp_t o,
                              output logic unstable, output bit done);
        int stalls, reqc;
        o.stalls = 0; o.reqc = 0; o.addr = '0; o.we = 1'b0; o.wdata = '0; o.be = '0;
        o.ld = '0; o.berr = 1'b0; o.merr = 1'b0;
        unstable = 1'b0; done = 1'b0; stalls = 0; reqc = 0;
        @(negedge clk);
        mem_read_in = v.rd; mem_write_in = v.wr; addr_in = v.addr;
        store_data_in = v.sd; funct3_in = v.f3; hold_in = 1'b0; dmem_ack = 1'b0;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (!mem_stall) begin
                done = 1'b1;
                o.ld = load_data_out; o.berr = bus_err; o.merr = misalign_err;
                mem_read_in = 1'b0; mem_write_in = 1'b0; addr_in = $urandom();
                dmem_ack = 1'($urandom_range(0, 1));
                hold_in = (v.hold_n > 0);
                break;
            end
            stalls++;
            if (dmem_req) begin
                reqc++;
                if (reqc == 1) begin
                    o.addr = dmem_addr; o.we = dmem_we; o.wdata = dmem_wdata; o.be = dmem_be;
                end else if (dmem_addr !== o.addr || dmem_we !== o.we ||
                             dmem_wdata !== o.wdata || dmem_be !== o.be) begin
                    unstable = 1'b1;
                end
                dmem_ack   = (v.ack_lat >= 0) && (reqc > v.ack_lat);
                dmem_rdata = dmem_ack ? v.rdata : $urandom();
            end else begin
                dmem_ack   = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom();
            end
            @(negedge clk);
        end
        o.stalls = stalls;
        o.reqc   = reqc;
        @(negedge clk);
        for (int h = 0; h < v.hold_n; h++) begin
            #1;
            chk($sformatf("%s.hold_ld", tag), load_data_out, o.ld);
            chk($sformatf("%s.hold_berr", tag), bus_err, o.berr);
            chk($sformatf("%s.hold_stall", tag), mem_stall, 0);
            if (h == v.hold_n - 1) hold_in = 1'b0;
            @(negedge clk);
        end
        #1;
        chk($sformatf("%s.exit_berr", tag), bus_err, 0);
        chk($sformatf("%s.exit_merr", tag), misalign_err, 0);
        chk($sformatf("%s.exit_stall", tag), mem_stall, 0);
        chk($sformatf("%s.exit_req", tag), dmem_req, 0);
        dmem_ack = 1'b0;
    endtask

    task automatic compare(input string tag, input vec_t v, input exp_t e, input exp_t o,
                           input logic unstable, input bit done);
        chk($sformatf("%s.done", tag), done, 1);
        chk($sformatf("%s.stalls", tag), o.stalls, e.stalls);
        chk($sformatf("%s.reqc", tag), o.reqc, e.reqc);
        if (e.reqc > 0) begin
            chk($sformatf("%s.addr", tag), o.addr, e.addr);
            chk($sformatf("%s.we", tag), o.we, e.we);
            chk($sformatf("%s.stable", tag), unstable, 0);
            if (v.f3 inside {3'b000, 3'b001, 3'b010}) chk($sformatf("%s.be", tag), o.be, e.be);
            if (v.wr) chk($sformatf("%s.wdata", tag), o.wdata, e.wdata);
        end
        chk($sformatf("%s.ld", tag), o.ld, e.ld);
        chk($sformatf("%s.berr", tag), o.berr, e.berr);
        chk($sformatf("%s.merr", tag), o.merr, e.merr);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t        tbl[12];
        exp_t        o, e;
        vec_t        v;
        logic        unstable;
        bit          done;
        logic [31:0] model_ld;
        logic [2:0]  f3s[5];

        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        tbl[0]  = mk(0, 1, 32'h100, 32'hDEADBEEF, 3'b010, 0, 32'h0, 0,
                     2, 1, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 0, 0);
        tbl[1]  = mk(0, 1, 32'h103, 32'h000000A5, 3'b000, 1, 32'h0, 0,
                     3, 2, 32'h100, 4'h8, 32'hA5A5A5A5, 32'h0, 0, 0);
        tbl[2]  = mk(1, 0, 32'h202, 32'h0, 3'b000, 0, 32'h12F03456, 0,
                     2, 1, 32'h200, 4'h4, 32'h0, 32'hFFFFFFF0, 0, 0);
        tbl[3]  = mk(1, 0, 32'h202, 32'h0, 3'b100, 0, 32'h12F03456, 0,
                     2, 1, 32'h200, 4'hF, 32'h0, 32'h000000F0, 0, 0);
        tbl[4]  = mk(1, 0, 32'h202, 32'h0, 3'b101, 0, 32'h12F03456, 0,
                     2, 1, 32'h200, 4'hF, 32'h0, 32'h000012F0, 0, 0);
        tbl[5]  = mk(1, 0, 32'h200, 32'h0, 3'b001, 2, 32'h00008001, 3,
                     4, 3, 32'h200, 4'h3, 32'h0, 32'hFFFF8001, 0, 0);
        tbl[6]  = mk(1, 0, 32'h300, 32'h0, 3'b010, -1, 32'h0, 1,
                     5, 4, 32'h300, 4'hF, 32'h0, 32'h0, 1, 0);
        tbl[7]  = mk(0, 1, 32'h106, 32'h1234ABCD, 3'b001, 0, 32'h0, 0,
                     2, 1, 32'h104, 4'hC, 32'hABCDABCD, 32'h0, 0, 0);
        tbl[8]  = mk(1, 1, 32'h10C, 32'hCAFEF00D, 3'b010, 0, 32'h11111111, 0,
                     2, 1, 32'h10C, 4'hF, 32'hCAFEF00D, 32'h0, 0, 0);
`ifdef MISALIGN_TRAP_EN
        tbl[9]  = mk(1, 0, 32'h301, 32'h0, 3'b010, 0, 32'h89ABCDEF, 0,
                     1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 0, 1);
`else
        tbl[9]  = mk(1, 0, 32'h301, 32'h0, 3'b010, 0, 32'h89ABCDEF, 0,
                     2, 1, 32'h300, 4'hF, 32'h0, 32'h89ABCDEF, 0, 0);
`endif
        tbl[10] = mk(1, 0, 32'h001, 32'h0, 3'b000, 0, 32'h00007F00, 0,
                     2, 1, 32'h0, 4'h2, 32'h0, 32'h0000007F, 0, 0);
        tbl[11] = mk(1, 0, 32'h004, 32'h0, 3'b010, 1, 32'h55AA33CC, 2,
                     3, 2, 32'h4, 4'hF, 32'h0, 32'h55AA33CC, 0, 0);

        // clock / reset
        rst = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b0; hold_in = 1'b0;
        dmem_ack = 1'b0; addr_in = '0; store_data_in = '0; funct3_in = '0; dmem_rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.req", dmem_req, 0);
        chk("rst.we", dmem_we, 0);
        chk("rst.addr", dmem_addr, 0);
        chk("rst.wdata", dmem_wdata, 0);
        chk("rst.be", dmem_be, 0);
        chk("rst.ld", load_data_out, 0);
        chk("rst.berr", bus_err, 0);
        chk("rst.merr", misalign_err, 0);
        chk("rst.stall", mem_stall, 0);

        // directed table
        for (int i = 0; i < 12; i++) begin
            run_access($sformatf("tbl%0d", i), tbl[i].v, o, unstable, done);
            compare($sformatf("tbl%0d", i), tbl[i].v, tbl[i].e, o, unstable, done);
        end
        model_ld = tbl[11].e.ld;

        // randomized accesses against the model
        for (int n = 0; n < 150; n++) begin
            v.wr      = 1'($urandom_range(0, 1));
            v.rd      = v.wr ? 1'($urandom_range(0, 1)) : 1'b1;
            v.f3      = f3s[$urandom_range(0, v.wr ? 2 : 4)];
            v.addr    = $urandom();
            v.sd      = $urandom();
            v.rdata   = $urandom();
            v.ack_lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
            v.hold_n  = int'($urandom_range(0, 2));
            e = model(v, model_ld);
            exp_q.push_back(e.ld);
            run_access($sformatf("rnd%0d", n), v, o, unstable, done);
            e.ld = exp_q.pop_front();
            model_ld = e.ld;
            compare($sformatf("rnd%0d", n), v, e, o, unstable, done);
        end

        // reset in the second REQ cycle with ack still pending
        @(negedge clk);
        mem_read_in = 1'b1; mem_write_in = 1'b0; addr_in = 32'h400; funct3_in = 3'b010;
        dmem_ack = 1'b0;
        @(negedge clk);
        #1;
        chk("rstreq.req1", dmem_req, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_read_in = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hFEEDFACE;
        #1;
        chk("rstreq.req", dmem_req, 0);
        chk("rstreq.be", dmem_be, 0);
        chk("rstreq.addr", dmem_addr, 0);
        chk("rstreq.ld", load_data_out, 0);
        chk("rstreq.stall", mem_stall, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("lateack%0d.req", k), dmem_req, 0);
            chk($sformatf("lateack%0d.stall", k), mem_stall, 0);
            chk($sformatf("lateack%0d.ld", k), load_data_out, 0);
            chk($sformatf("lateack%0d.berr", k), bus_err, 0);
        end
        dmem_ack = 1'b0;

        // recovery access after the abandoned request
        v.rd = 1'b1; v.wr = 1'b0; v.addr = 32'h500; v.sd = 32'h0; v.f3 = 3'b010;
        v.ack_lat = 0; v.rdata = 32'hA1B2C3D4; v.hold_n = 0;
        e = model(v, 32'h0);
        run_access("recover", v, o, unstable, done);
        compare("recover", v, e, o, unstable, done);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
